// File: rtl/steer_pkg.sv
// Shared types and default thresholds for the steering-enable controller.
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } state_t;

  localparam int          DEF_LD_W         = 12;
  localparam int unsigned DEF_MIN_RIDER_WT = 32'h200;
  localparam int unsigned DEF_WT_HYST      = 32'h40;

endpackage

// File: rtl/steer_ld_cmp.sv
// Registered load-cell compare stage: total weight against a hysteretic threshold
// and left/right imbalance against fractions of the total weight.
module steer_ld_cmp
  import steer_pkg::*;
#(
  parameter int              LD_W         = DEF_LD_W,
  parameter logic [LD_W-1:0] MIN_RIDER_WT = LD_W'(DEF_MIN_RIDER_WT),
  parameter logic [LD_W-1:0] WT_HYST      = LD_W'(DEF_WT_HYST)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            idle,
  output logic            sum_gt_min,
  output logic            diff_gt_1_4,
  output logic            diff_gt_15_16
);

  localparam logic [LD_W:0] THR_ON  = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
  localparam logic [LD_W:0] THR_OFF = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

  logic [LD_W:0]   sum;
  logic [LD_W-1:0] diff;
  logic [LD_W:0]   diff_ext;
  logic [LD_W:0]   sum_15_16;

  logic sum_gt_min_next;
  logic diff_gt_1_4_next;
  logic diff_gt_15_16_next;

  logic sum_gt_min_reg;
  logic diff_gt_1_4_reg;
  logic diff_gt_15_16_reg;

  always_comb begin
    sum       = {1'b0, lft_ld} + {1'b0, rght_ld};
    diff      = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    diff_ext  = {1'b0, diff};
    sum_15_16 = sum - (sum >> 4);

    // Stricter entry threshold while idle, relaxed hold threshold once a rider is on.
    sum_gt_min_next    = idle ? (sum > THR_ON) : (sum >= THR_OFF);
    diff_gt_1_4_next   = diff_ext > (sum >> 2);
    diff_gt_15_16_next = diff_ext > sum_15_16;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_gt_min_reg    <= 1'b0;
      diff_gt_1_4_reg   <= 1'b0;
      diff_gt_15_16_reg <= 1'b0;
    end else begin
      sum_gt_min_reg    <= sum_gt_min_next;
      diff_gt_1_4_reg   <= diff_gt_1_4_next;
      diff_gt_15_16_reg <= diff_gt_15_16_next;
    end
  end

  assign sum_gt_min    = sum_gt_min_reg;
  assign diff_gt_1_4   = diff_gt_1_4_reg;
  assign diff_gt_15_16 = diff_gt_15_16_reg;

endmodule

// File: rtl/steer_en_ctrl.sv
// Rider-detect and steering-enable FSM; drives the piezo driver's en_steer and
// balance-timer clear from registered load-cell compare flags.
module steer_en_ctrl
  import steer_pkg::*;
#(
  parameter int              LD_W         = DEF_LD_W,
  parameter logic [LD_W-1:0] MIN_RIDER_WT = LD_W'(DEF_MIN_RIDER_WT),
  parameter logic [LD_W-1:0] WT_HYST      = LD_W'(DEF_WT_HYST)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            tmr_full,
  output logic            en_steer,
  output logic            clr_tmr,
  output logic            rider_off
);

  state_t state_reg;
  state_t state_next;

  logic en_steer_reg,  en_steer_next;
  logic clr_tmr_reg,   clr_tmr_next;
  logic rider_off_reg, rider_off_next;

  logic sum_gt_min;
  logic diff_gt_1_4;
  logic diff_gt_15_16;
  logic idle;

  assign idle = (state_reg == IDLE);

  steer_ld_cmp #(
    .LD_W         (LD_W),
    .MIN_RIDER_WT (MIN_RIDER_WT),
    .WT_HYST      (WT_HYST)
  ) u_ld_cmp (
    .clk           (clk),
    .rst           (rst),
    .lft_ld        (lft_ld),
    .rght_ld       (rght_ld),
    .idle          (idle),
    .sum_gt_min    (sum_gt_min),
    .diff_gt_1_4   (diff_gt_1_4),
    .diff_gt_15_16 (diff_gt_15_16)
  );

  // Priority in every riding state: weight loss, then imbalance, then timer.
  always_comb begin
    state_next   = state_reg;
    clr_tmr_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sum_gt_min) begin
          state_next   = WAIT;
          clr_tmr_next = 1'b1;
        end
      end
      WAIT: begin
        if (!sum_gt_min) begin
          state_next = IDLE;
        end else if (diff_gt_1_4) begin
          clr_tmr_next = 1'b1;
        end else if (tmr_full) begin
          state_next = STEER_EN;
        end
      end
      STEER_EN: begin
        if (!sum_gt_min) begin
          state_next = IDLE;
        end else if (diff_gt_15_16) begin
          state_next   = WAIT;
          clr_tmr_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    en_steer_next  = (state_next == STEER_EN);
    rider_off_next = (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      en_steer_reg  <= 1'b0;
      clr_tmr_reg   <= 1'b0;
      rider_off_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      en_steer_reg  <= en_steer_next;
      clr_tmr_reg   <= clr_tmr_next;
      rider_off_reg <= rider_off_next;
    end
  end

  assign en_steer  = en_steer_reg;
  assign clr_tmr   = clr_tmr_reg;
  assign rider_off = rider_off_reg;

endmodule

// File: doc/steer_en_ctrl.md
Name: steer_en_ctrl

Overview:
- Rider-detect and steering-enable controller.
- Sits directly upstream of the piezo driver and produces two of its inputs:
  - en_steer
  - steer_en_clr_tmr (driven by this block's clr_tmr port)
- Consumes the piezo driver's steer_en_tmr_full on its tmr_full port.
- From the left and right load-cell readings it decides whether a rider is on the platform and balanced. Once the rider has held a balanced stance for the full timer period, it enables steering.

Parameters:
- LD_W, 12, load-cell reading width.
- MIN_RIDER_WT, 12'h200, nominal minimum total weight for a rider to be present.
- WT_HYST, 12'h40, hysteresis applied around MIN_RIDER_WT.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- lft_ld  input  LD_W  left load-cell reading, unsigned.
- rght_ld  input  LD_W  right load-cell reading, unsigned.
- tmr_full  input  1  balance timer expired; from the piezo driver's steer_en_tmr_full.
- en_steer  output  1  steering enabled; feeds the piezo driver's en_steer.
- clr_tmr  output  1  one-cycle pulse that restarts the balance timer; feeds steer_en_clr_tmr.
- rider_off  output  1  high when no rider is detected.

Interface decision: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state=IDLE, en_steer=0, clr_tmr=0, rider_off=1.
  - All compare flags cleared.
  - Reset mid-operation aborts any state immediately; en_steer drops on that same edge.
- Compare stage (registered, 1-cycle latency from lft_ld/rght_ld):
  - sum = lft_ld + rght_ld, LD_W+1 bits, no overflow.
  - diff = |lft_ld - rght_ld|, LD_W bits.
  - sum_gt_min:
    - in IDLE: sum > MIN_RIDER_WT + WT_HYST (0x240);
    - otherwise: sum >= MIN_RIDER_WT - WT_HYST (0x1C0).
    - The threshold select uses the current state.
  - diff_gt_1_4 = diff > (sum >> 2).
  - diff_gt_15_16 = diff > (sum - (sum >> 4)).
  - All compares are unsigned, at LD_W+1 bits.
- FSM (outputs registered):
  - Total latency from a load change to an output change is 2 cycles.
  - tmr_full is used unregistered, so latency from tmr_full to en_steer is 1 cycle.
  - IDLE:
    - if sum_gt_min: go to WAIT; pulse clr_tmr; rider_off=0.
    - else: stay; rider_off=1.
  - WAIT:
    - if !sum_gt_min: go to IDLE; rider_off=1.
    - elif diff_gt_1_4: stay; pulse clr_tmr.
    - elif tmr_full: go to STEER_EN; en_steer=1.
    - else: stay.
  - STEER_EN:
    - if !sum_gt_min: go to IDLE; en_steer=0; rider_off=1.
    - elif diff_gt_15_16: go to WAIT; en_steer=0; pulse clr_tmr.
    - else: stay; en_steer=1.
- Priority on simultaneous events: weight loss > imbalance > tmr_full. Example: tmr_full together with diff_gt_1_4 in WAIT gives clr_tmr and no enable.
- clr_tmr is high for exactly one cycle per qualifying edge.
  - While WAIT stays imbalanced, clr_tmr re-pulses every cycle; this is intended and holds the timer in reset.
- en_steer is low in IDLE and WAIT and high only in STEER_EN.
- rider_off is the inverse of (state != IDLE), registered.
- Boundaries:
  - sum is exactly 0x240 in IDLE: no transition (strict >).
  - sum is exactly 0x1C0 while riding: the rider stays (>=).
  - sum=0: all diff flags are 0, and weight loss dominates.
  - Maximum loads (0xFFF+0xFFF=0x1FFE): no wrap.

Decomposition:
- steer_pkg holds:
  - the state typedef enum {IDLE, WAIT, STEER_EN};
  - default constants MIN_RIDER_WT and WT_HYST.
- Sub-module steer_ld_cmp:
  - contains the registered sum/diff/flag stage;
  - takes the state-based threshold select as an input.
- The top level holds the FSM and the output registers.

Test Plan:
- Reset, then lft=rght=0 for 10 cycles -> en_steer=0, rider_off=1, clr_tmr never pulses.
- lft=rght=0x110 (sum 0x220) -> stays IDLE. Raise to 0x130 each (sum 0x260) -> 2 cycles later clr_tmr pulses once and rider_off=0.
- In WAIT with lft=rght=0x300, assert tmr_full -> en_steer=1 on the next edge.
- Same setup, but lft=0x500, rght=0x100 (diff 0x400 > 0x180) together with tmr_full -> clr_tmr pulses every cycle and en_steer stays 0.
- In STEER_EN, step off with lft=0x5F0, rght=0x010 (diff 0x5E0 > 0x5A0) -> after 2 cycles en_steer=0, clr_tmr pulses, state=WAIT.
- In STEER_EN, sum 0x1D0 -> en_steer holds 1. Then sum 0x1B0 -> en_steer=0 and rider_off=1. Then assert rst in WAIT -> all outputs return to reset values on the next edge.
